// File: rtl/z80_xfer_pkg.sv
// Shared definitions for the Z80 multi-byte memory transfer sequencer.
//   xfer_state_t         : sequencer states (IDLE, T1, T2, T3, DONE)
//   XFER_MAX_BYTES_LIMIT : largest transfer width the sequencer supports
package z80_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        DONE = 3'd4
    } xfer_state_t;

    localparam int XFER_MAX_BYTES_LIMIT = 8;

endpackage

// File: rtl/z80_mem_xfer_seq_if.sv
// Request and memory-bus bundle for z80_mem_xfer_seq.
//   Request side : start, write, nbytes, addr, wdata -> busy, done, rdata
//   Memory side  : mem_addr, mem_rd, mem_wr, mem_wdata -> mem_rdata, mem_wait
// modport slave is the sequencer; modport master is the executor plus memory.
interface z80_mem_xfer_seq_if #(
    parameter int MAX_BYTES = 2,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
);
    logic                   start;
    logic                   write;
    logic [CNT_W-1:0]       nbytes;
    logic [ADDR_W-1:0]      addr;
    logic [8*MAX_BYTES-1:0] wdata;
    logic                   busy;
    logic                   done;
    logic [8*MAX_BYTES-1:0] rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [7:0]             mem_wdata;
    logic [7:0]             mem_rdata;
    logic                   mem_wait;

    modport master (
        output start, write, nbytes, addr, wdata, mem_rdata, mem_wait,
        input  busy, done, rdata, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  start, write, nbytes, addr, wdata, mem_rdata, mem_wait,
        output busy, done, rdata, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/z80_mem_xfer_seq.sv
// Multi-byte little-endian memory transfer sequencer.
// Runs a load or store of up to MAX_BYTES bytes as T1/T2/T3 byte machine
// cycles starting at a base address, wrapping modulo 2^ADDR_W.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : z80_mem_xfer_seq_if.slave (request + memory bus signals)
//   trace_*    : only when Z80FI_TRACE_EN is defined; trace_valid pulses with
//                done, trace_addr0/1 are the first/last byte addresses driven,
//                trace_rw is the transfer direction.
module z80_mem_xfer_seq
    import z80_xfer_pkg::*;
#(
    parameter int MAX_BYTES = 2,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    z80_mem_xfer_seq_if.slave  bus
`ifdef Z80FI_TRACE_EN
    ,
    output logic               trace_valid,
    output logic [ADDR_W-1:0]  trace_addr0,
    output logic [ADDR_W-1:0]  trace_addr1,
    output logic               trace_rw
`endif
);

    // Widths above the architectural limit are trimmed for the count clamp.
    localparam int MAX_EFF = (MAX_BYTES > XFER_MAX_BYTES_LIMIT) ? XFER_MAX_BYTES_LIMIT : MAX_BYTES;

    xfer_state_t            state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   mem_rd_q;
    logic                   mem_wr_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [7:0]             mem_wdata_q;
    logic [CNT_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   write_q;
    logic [8*MAX_BYTES-1:0] wdata_q;

    logic                   accept_d;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       idx_inc_d;
    logic [CNT_W-1:0]       sel_idx_d;
    logic [8*MAX_BYTES-1:0] src_wdata_d;
    logic [7:0]             lane_byte_d;
    logic [7:0]             lane_wd [MAX_BYTES];

    assign accept_d  = (state_q == IDLE) && bus.start;
    assign cnt_d     = (bus.nbytes > CNT_W'(MAX_EFF)) ? CNT_W'(MAX_EFF) : bus.nbytes;
    assign idx_inc_d = idx_q + CNT_W'(1);

    // The byte to put on the bus next: byte 0 of the incoming request when
    // starting, otherwise the following byte of the latched store data.
    assign sel_idx_d   = (state_q == IDLE) ? '0 : idx_inc_d;
    assign src_wdata_d = (state_q == IDLE) ? bus.wdata : wdata_q;

    for (genvar k = 0; k < MAX_BYTES; k++) begin : g_lane
        logic [7:0] rbyte_q;

        assign lane_wd[k] = (sel_idx_d == CNT_W'(k)) ? src_wdata_d[8*k +: 8] : 8'h00;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rbyte_q <= 8'h00;
            end else if (accept_d) begin
                rbyte_q <= 8'h00;
            end else if (state_q == T3 && !write_q && idx_q == CNT_W'(k)) begin
                rbyte_q <= bus.mem_rdata;
            end
        end

        assign bus.rdata[8*k +: 8] = rbyte_q;
    end

    always_comb begin
        lane_byte_d = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            lane_byte_d = lane_byte_d | lane_wd[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            idx_q       <= '0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        write_q <= bus.write;
                        wdata_q <= bus.wdata;
                        cnt_q   <= cnt_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        if (cnt_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= T1;
                            mem_addr_q  <= bus.addr;
                            mem_wdata_q <= lane_byte_d;
                            mem_rd_q    <= !bus.write;
                            mem_wr_q    <= bus.write;
                        end
                    end
                end
                T1: state_q <= T2;
                T2: begin
                    if (!bus.mem_wait) begin
                        state_q <= T3;
                    end
                end
                T3: begin
                    idx_q <= idx_inc_d;
                    if (idx_inc_d < cnt_q) begin
                        // Strobes stay up into the next byte's T1; the address
                        // advances and wraps naturally at ADDR_W bits.
                        state_q     <= T1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= lane_byte_d;
                    end else begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef Z80FI_TRACE_EN
    logic [ADDR_W-1:0] trace_addr0_q;
    logic [ADDR_W-1:0] trace_addr1_q;
    logic              trace_rw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_addr0_q <= '0;
            trace_addr1_q <= '0;
            trace_rw_q    <= 1'b0;
        end else if (accept_d) begin
            trace_addr0_q <= bus.addr;
            trace_addr1_q <= bus.addr;
            trace_rw_q    <= bus.write;
        end else if (state_q == T3 && idx_inc_d < cnt_q) begin
            trace_addr1_q <= mem_addr_q + ADDR_W'(1);
        end
    end

    assign trace_valid = done_q;
    assign trace_addr0 = trace_addr0_q;
    assign trace_addr1 = trace_addr1_q;
    assign trace_rw    = trace_rw_q;
`endif

endmodule
